reg4_ctrl_seq: RTL
==================

// Module: reg4_ctrl_seq
// PURPOSE
//   Command sequencer sitting directly upstream of the 4-bit clear/load/increment register.
//   Accepts one command per valid/ready handshake and drives the register's clear, load,
//   inr and data inputs as single-cycle, mutually exclusive strobes.
//   Reports busy/done to the host; optionally checks the register output against a shadow model.
// PARAMETERS
//   WIDTH  4  register data width
//   CNT_W  4  width of increment-count field (max 2^CNT_W-1 increments per command)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      reset: synchronous, active-low
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      sequencer idle, can accept
//   cmd_op     in   2      00 CLR, 01 LOAD, 10 INC, 11 LOAD_INC
//   cmd_data   in   WIDTH  load value (LOAD, LOAD_INC)
//   cmd_cnt    in   CNT_W  number of increments (INC, LOAD_INC)
//   reg_clear  out  1      clear strobe to register
//   reg_load   out  1      load strobe to register
//   reg_inr    out  1      increment strobe to register
//   reg_data   out  WIDTH  load data to register
//   reg_q      in   WIDTH  register output (used only with SEQ_SHADOW_CHECK_EN)
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle pulse, command complete
//   mismatch   out  1      sticky shadow-check error
// BEHAVIOUR
//   - rst_n=0 at edge: state IDLE, all outputs 0 (incl. reg_data, done, mismatch), counter 0.
//   - cmd_ready = (state==IDLE) && rst_n. Accept on cmd_valid && cmd_ready at edge T; latch op/data/cnt.
//   - cmd_valid while busy is ignored; no queueing.
//   - FSM states: IDLE, CLR, LOAD, INC, DONE. All strobes registered; at most one high per cycle.
//   - CLR: reg_clear=1 in cycle T+1 -> DONE. LOAD: reg_load=1 in T+1 -> DONE.
//   - INC: cnt==0 -> straight to DONE (done in T+1); else reg_inr=1 for exactly cnt cycles.
//   - LOAD_INC: LOAD (T+1), then INC phase (cnt cycles; skipped if cnt==0).
//   - DONE: done=1 one cycle, next state IDLE. Done cycle = T+1+number_of_strobes.
//   - reg_data = latched cmd_data from T+1 until the next accept; 0 after reset.
//   - Internal down-counter CNT_W bits; loaded with cnt, decremented per inr strobe, no wrap.
//   - Register wrap (e.g. 14+3 -> 1) is the register's concern; sequencer does not saturate.
//   - rst_n low mid-command: strobes 0 after that edge, command discarded, no done pulse.
// CONFIGURATION
//   SEQ_SHADOW_CHECK_EN defined:
//     - shadow register + valid bit; valid cleared by reset, set by CLR/LOAD strobes.
//     - shadow updates on strobe edges: clear->0, load->reg_data, inr->shadow+1 mod 2^WIDTH.
//     - in DONE, if valid && reg_q != shadow: mismatch set next cycle, sticky until rst_n=0.
//   Not defined: no shadow logic, reg_q ignored, mismatch tied 0.
// STRUCTURE
//   Package reg4_seq_pkg: op codes (CLR/LOAD/INC/LOAD_INC), FSM state encoding, WIDTH/CNT_W defaults.
//   Sub-module reg4_shadow_model (instantiated only under SEQ_SHADOW_CHECK_EN); FSM and counter in top.
// TESTING (bench instantiates this block driving the real 4-bit register)
//   1. Reset, CLR accepted at T -> reg_clear=1 only in T+1, done=1 at T+2, q=0.
//   2. LOAD data=5 -> reg_load=1 at T+1 with reg_data=5, cmd_ready=0 T+1..T+2, done at T+2, q=5.
//   3. LOAD_INC data=5 cnt=3 -> load T+1, reg_inr T+2..T+4, done T+5, q=8; busy T+1..T+5.
//   4. LOAD_INC data=14 cnt=3 -> q=1, mismatch=0; with macro, force reg_q=7 in DONE -> mismatch=1, sticky.
//   5. INC cnt=0 -> no strobes, done at T+1; cmd_valid held during busy in test 3 -> no second accept.
//   6. rst_n=0 during inr burst (after 2 strobes) -> strobes 0 next edge, no done, cmd_ready=1 after release.

Source files
------------

// File: rtl/reg4_seq_pkg.sv
// Shared types for the 4-bit register command sequencer: op codes, FSM states, default widths.
package reg4_seq_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_CLR      = 2'b00,
    OP_LOAD     = 2'b01,
    OP_INC      = 2'b10,
    OP_LOAD_INC = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_INC  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/reg4_shadow_model.sv
// Shadow copy of the downstream 4-bit register; flags a sticky mismatch when the real register
// disagrees at command completion. Only instantiated when SEQ_SHADOW_CHECK_EN is defined.
module reg4_shadow_model
  import reg4_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reg_clear,
  input  logic             reg_load,
  input  logic             reg_inr,
  input  logic [WIDTH-1:0] reg_data,
  input  logic [WIDTH-1:0] reg_q,
  input  logic             check,
  output logic             mismatch
);

  logic [WIDTH-1:0] shadow;
  logic             valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow   <= '0;
      valid    <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      if (reg_clear) begin
        shadow <= '0;
        valid  <= 1'b1;
      end else if (reg_load) begin
        shadow <= reg_data;
        valid  <= 1'b1;
      end else if (reg_inr) begin
        shadow <= shadow + 1'b1;
      end
      // Until a clear or load has been seen the register contents are unknown, so no check.
      if (check && valid && (reg_q != shadow))
        mismatch <= 1'b1;
    end
  end

endmodule

// File: rtl/reg4_ctrl_seq.sv
// Command sequencer for the 4-bit clear/load/increment register: one command per handshake,
// single-cycle mutually exclusive strobes. Optional shadow check under SEQ_SHADOW_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// CLR     | reg_clear strobe this cycle
// LOAD    | reg_load strobe this cycle (LOAD or first phase of LOAD_INC)
// INC     | reg_inr strobe this cycle, cnt_q strobes remaining including this one
// DONE    | done pulse, back to IDLE next
module reg4_ctrl_seq
  import reg4_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             reg_clear,
  output logic             reg_load,
  output logic             reg_inr,
  output logic [WIDTH-1:0] reg_data,
  input  logic [WIDTH-1:0] reg_q,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  state_e           state;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;

  assign cmd_ready = (state == ST_IDLE) && rst_n;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_CLR;
      cnt_q     <= '0;
      reg_clear <= 1'b0;
      reg_load  <= 1'b0;
      reg_inr   <= 1'b0;
      reg_data  <= '0;
      done      <= 1'b0;
    end else begin
      reg_clear <= 1'b0;
      reg_load  <= 1'b0;
      reg_inr   <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q     <= op_e'(cmd_op);
            reg_data <= cmd_data;
            cnt_q    <= cmd_cnt;
            unique case (op_e'(cmd_op))
              OP_CLR: begin
                state     <= ST_CLR;
                reg_clear <= 1'b1;
              end
              OP_LOAD, OP_LOAD_INC: begin
                state    <= ST_LOAD;
                reg_load <= 1'b1;
              end
              OP_INC: begin
                if (cmd_cnt == '0) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end else begin
                  state   <= ST_INC;
                  reg_inr <= 1'b1;
                end
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_CLR: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_LOAD: begin
          if ((op_q == OP_LOAD_INC) && (cnt_q != '0)) begin
            state   <= ST_INC;
            reg_inr <= 1'b1;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_INC: begin
          // The strobe visible this cycle consumes one count at the closing edge.
          if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
          if ((cnt_q == CNT_W'(1)) || (cnt_q == '0)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            reg_inr <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SEQ_SHADOW_CHECK_EN
  reg4_shadow_model #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .reg_clear(reg_clear),
    .reg_load (reg_load),
    .reg_inr  (reg_inr),
    .reg_data (reg_data),
    .reg_q    (reg_q),
    .check    (state == ST_DONE),
    .mismatch (mismatch)
  );
`else
  logic unused_reg_q;
  assign unused_reg_q = ^reg_q;
  assign mismatch     = 1'b0;
`endif

endmodule
